// File: rtl/game_link_ctrl.sv
// Link/sequencing controller between the game FSM and the UART pair: SYNC/ACK start handshake,
// GAME phase timing, and score exchange with the rival board.
module game_link_ctrl #(
    parameter int unsigned GAME_CYCLES    = 1_950_000_000,
    parameter int unsigned RESEND_CYCLES  = 650_000,
    parameter int unsigned TIMEOUT_CYCLES = 65_000_000,
    parameter logic [7:0]  SYNC_B         = 8'hA5,
    parameter logic [7:0]  ACK_B          = 8'h5A,
    parameter logic [7:0]  HDR_B          = 8'hC3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state_in,
    input  logic [7:0] my_score,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       start_sig,
    output logic       end_of_time,
    output logic [7:0] rival_score,
    output logic       link_err
);

    localparam int unsigned GW = $clog2(GAME_CYCLES + 1);
    localparam int unsigned RW = $clog2(RESEND_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [GW-1:0] GAME_LAST    = GW'(GAME_CYCLES - 1);
    localparam logic [GW-1:0] GAME_MAX     = GW'(GAME_CYCLES);
    localparam logic [RW-1:0] RESEND_LAST  = RW'(RESEND_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_WAIT  = 2'b01;
    localparam logic [1:0] S_GAME  = 2'b10;
    localparam logic [1:0] S_SCORE = 2'b11;

    localparam logic [3:0] L_IDLE       = 4'd0;
    localparam logic [3:0] L_SYNC_TX    = 4'd1;
    localparam logic [3:0] L_SYNC_WAIT  = 4'd2;
    localparam logic [3:0] L_ACK_TX     = 4'd3;
    localparam logic [3:0] L_RUN        = 4'd4;
    localparam logic [3:0] L_HDR_TX     = 4'd5;
    localparam logic [3:0] L_DAT_TX     = 4'd6;
    localparam logic [3:0] L_SCORE_WAIT = 4'd7;
    localparam logic [3:0] L_DONE       = 4'd8;

    logic [3:0]    lstate;
    logic          armed;
    logic          rival_valid;
    logic [RW-1:0] resend_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [GW-1:0] game_cnt;
    logic [1:0]    state_prev;

    logic sync_seen, ack_seen, score_strobe, tx_ok;

    // A byte following HDR_B is score data, so it never counts as SYNC or ACK.
    assign sync_seen    = rx_valid && !armed && (rx_data == SYNC_B);
    assign ack_seen     = rx_valid && !armed && (rx_data == ACK_B);
    assign score_strobe = rx_valid && armed;
    assign tx_ok        = tx_ready && !tx_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            lstate      <= L_IDLE;
            armed       <= 1'b0;
            rival_valid <= 1'b0;
            rival_score <= '0;
            resend_cnt  <= '0;
            timeout_cnt <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            start_sig   <= 1'b0;
            link_err    <= 1'b0;
        end else if (state_in == S_IDLE) begin
            lstate      <= L_IDLE;
            armed       <= 1'b0;
            rival_valid <= 1'b0;
            resend_cnt  <= '0;
            timeout_cnt <= '0;
            tx_start    <= 1'b0;
            start_sig   <= 1'b0;
            link_err    <= 1'b0;
        end else begin
            tx_start <= 1'b0;

            if (rx_valid) begin
                if (armed) begin
                    rival_score <= rx_data;
                    rival_valid <= 1'b1;
                    armed       <= 1'b0;
                end else if (rx_data == HDR_B) begin
                    armed <= 1'b1;
                end
            end

            case (lstate)
                L_IDLE: begin
                    if (state_in == S_WAIT) lstate <= L_SYNC_TX;
                end
                L_SYNC_TX: begin
                    if (tx_ok) begin
                        tx_start   <= 1'b1;
                        tx_data    <= SYNC_B;
                        resend_cnt <= '0;
                        lstate     <= L_SYNC_WAIT;
                    end
                end
                L_SYNC_WAIT: begin
                    if (sync_seen) begin
                        lstate <= L_ACK_TX;
                    end else if (ack_seen) begin
                        lstate    <= L_RUN;
                        start_sig <= 1'b1;
                    end else if (resend_cnt == RESEND_LAST) begin
                        lstate <= L_SYNC_TX;
                    end else begin
                        resend_cnt <= resend_cnt + RW'(1);
                    end
                end
                L_ACK_TX: begin
                    if (tx_ok) begin
                        tx_start  <= 1'b1;
                        tx_data   <= ACK_B;
                        lstate    <= L_RUN;
                        start_sig <= 1'b1;
                    end
                end
                L_RUN: begin
                    if (state_in == S_SCORE) lstate <= L_HDR_TX;
                end
                L_HDR_TX: begin
                    if (tx_ok) begin
                        tx_start <= 1'b1;
                        tx_data  <= HDR_B;
                        lstate   <= L_DAT_TX;
                    end
                end
                L_DAT_TX: begin
                    if (tx_ok) begin
                        tx_start    <= 1'b1;
                        tx_data     <= my_score;
                        timeout_cnt <= '0;
                        lstate      <= L_SCORE_WAIT;
                    end
                end
                L_SCORE_WAIT: begin
                    // A score landing on the expiry cycle still counts as received.
                    if (rival_valid || score_strobe) begin
                        lstate <= L_DONE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        link_err    <= 1'b1;
                        rival_score <= '0;
                        lstate      <= L_DONE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end
                L_DONE: begin
                end
                default: lstate <= L_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            game_cnt    <= '0;
            state_prev  <= S_IDLE;
            end_of_time <= 1'b0;
        end else begin
            state_prev <= state_in;
            if (state_in == S_GAME) begin
                if (state_prev != S_GAME) begin
                    game_cnt <= '0;
                end else if (game_cnt != GAME_MAX) begin
                    game_cnt <= game_cnt + GW'(1);
                end
            end
            // The entry cycle is excluded because game_cnt still holds the previous round's count.
            end_of_time <= (state_in == S_GAME) && (state_prev == S_GAME) &&
                           (game_cnt >= GAME_LAST);
        end
    end

endmodule

// File: tb/tb_game_link_ctrl.sv
// Directed bench for game_link_ctrl: vector table for the handshake start, hand-written
// sequences for resend, game timer, score exchange, timeout and abort.
module tb_game_link_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_in;
    logic [7:0] my_score;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       start_sig;
    logic       end_of_time;
    logic [7:0] rival_score;
    logic       link_err;

    int n_chk  = 0;
    int n_fail = 0;

    game_link_ctrl #(
        .GAME_CYCLES   (20),
        .RESEND_CYCLES (8),
        .TIMEOUT_CYCLES(30)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .state_in   (state_in),
        .my_score   (my_score),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .start_sig  (start_sig),
        .end_of_time(end_of_time),
        .rival_score(rival_score),
        .link_err   (link_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       rv;
        logic [7:0] rd;
        logic       rdy;
        logic       exp_txs;
        logic [7:0] exp_txd;
        logic       exp_ss;
    } vec_t;

    vec_t tbl[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_tx(input string nm, input int max, output int n);
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < max) begin
            step();
            n++;
            found = tx_start;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: got no tx_start expected one within %0d cycles", nm, max);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        state_in = 2'b00;
        my_score = 8'h00;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        int n;

        // st, rv, rd, rdy | tx_start, tx_data, start_sig
        tbl[0] = '{2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0}; // IDLE -> SYNC_TX
        tbl[1] = '{2'b01, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0}; // SYNC launched
        tbl[2] = '{2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0}; // waiting, data held
        tbl[3] = '{2'b01, 1'b1, 8'h5A, 1'b0, 1'b0, 8'hA5, 1'b1}; // ACK -> RUN, no ACK sent
        tbl[4] = '{2'b10, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1}; // first GAME cycle

        // Reset values
        do_reset();
        chk("rst_tx_start", 8'(tx_start), 8'h00);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_start_sig", 8'(start_sig), 8'h00);
        chk("rst_eot", 8'(end_of_time), 8'h00);
        chk("rst_rival", rival_score, 8'h00);
        chk("rst_link_err", 8'(link_err), 8'h00);
        rst = 1'b0;

        // Handshake via ACK path
        for (int i = 0; i < 5; i++) begin
            state_in = tbl[i].st;
            rx_valid = tbl[i].rv;
            rx_data  = tbl[i].rd;
            tx_ready = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d_tx_start", i), 8'(tx_start), 8'(tbl[i].exp_txs));
            chk($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].exp_txd);
            chk($sformatf("vec%0d_start_sig", i), 8'(start_sig), 8'(tbl[i].exp_ss));
        end
        rx_valid = 1'b0;

        // GAME timer with an early rival score (C3 header, C3 payload) mid-round
        for (int k = 2; k <= 20; k++) begin
            rx_valid = (k == 5) || (k == 6);
            rx_data  = 8'hC3;
            step();
        end
        rx_valid = 1'b0;
        chk("eot_before_expiry", 8'(end_of_time), 8'h00);
        chk("early_score", rival_score, 8'hC3);
        step();
        chk("eot_set", 8'(end_of_time), 8'h01);
        repeat (3) step();
        chk("eot_hold", 8'(end_of_time), 8'h01);

        // Score exchange
        state_in = 2'b11;
        my_score = 8'h2A;
        step();
        chk("eot_clear_on_score", 8'(end_of_time), 8'h00);
        wait_tx("hdr_launch", 5, n);
        chk("hdr_byte", tx_data, 8'hC3);
        wait_tx("score_launch", 5, n);
        chk("score_byte", tx_data, 8'h2A);
        repeat (3) step();
        chk("done_no_tx", 8'(tx_start), 8'h00);
        chk("done_link_err", 8'(link_err), 8'h00);
        chk("done_rival", rival_score, 8'hC3);

        // IDLE override keeps rival_score
        state_in = 2'b00;
        step();
        chk("idle_start_sig", 8'(start_sig), 8'h00);
        chk("idle_rival_hold", rival_score, 8'hC3);

        // Score timeout
        state_in = 2'b01;
        wait_tx("sync_round2", 5, n);
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        step();
        rx_valid = 1'b0;
        chk("round2_start_sig", 8'(start_sig), 8'h01);
        state_in = 2'b11;
        wait_tx("hdr_round2", 5, n);
        wait_tx("score_round2", 5, n);
        repeat (29) step();
        chk("timeout_not_yet", 8'(link_err), 8'h00);
        step();
        chk("timeout_link_err", 8'(link_err), 8'h01);
        chk("timeout_rival_zero", rival_score, 8'h00);
        state_in = 2'b00;
        step();
        chk("idle_clears_link_err", 8'(link_err), 8'h00);

        // SYNC resend: 8 idle cycles in SYNC_WAIT plus the SYNC_TX launch cycle
        do_reset();
        rst = 1'b0;
        state_in = 2'b01;
        wait_tx("sync_first", 5, n);
        wait_tx("sync_resend", 20, n);
        chk("resend_gap", 8'(n), 8'd9);
        chk("resend_byte", tx_data, 8'hA5);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        step();
        rx_valid = 1'b0;
        chk("ackpend_start_sig", 8'(start_sig), 8'h00);
        wait_tx("ack_launch", 5, n);
        chk("ack_byte", tx_data, 8'h5A);
        chk("ack_start_sig", 8'(start_sig), 8'h01);

        // Abort mid-GAME
        state_in = 2'b10;
        repeat (25) step();
        chk("abort_eot_before", 8'(end_of_time), 8'h01);
        state_in = 2'b00;
        tx_ready = 1'b0;
        step();
        chk("abort_eot", 8'(end_of_time), 8'h00);
        chk("abort_start_sig", 8'(start_sig), 8'h00);

        // Abort with a SYNC launch stalled on tx_ready
        state_in = 2'b01;
        repeat (3) step();
        chk("stall_no_tx", 8'(tx_start), 8'h00);
        state_in = 2'b00;
        step();
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("abort_no_tx%0d", k), 8'(tx_start), 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
